// File: rtl/handshake_pkg.sv
// Shared types and defaults for the req/ack handshake receive path.
// Imported by the responder top and its FIFO.
package handshake_pkg;

  localparam int DEF_DATA_WIDTH  = 32;
  localparam int DEF_FIFO_DEPTH  = 4;
  localparam int DEF_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    R_IDLE,
    R_WAIT_SPACE,
    R_ACK
  } resp_state_t;

endpackage

// File: rtl/flipflop_synchronizer.sv
// Multi-stage flop synchronizer for signals entering the clock domain.
// All stages reset to zero.
module flipflop_synchronizer #(
  parameter int WIDTH         = 1,
  parameter int NUM_OF_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o
);

  logic [NUM_OF_STAGES-1:0][WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= data_i;
      for (int i = 1; i < NUM_OF_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign data_o = sync_q[NUM_OF_STAGES-1];

endmodule

// File: rtl/responder_fifo.sv
// Circular-buffer FIFO holding captured handshake words.
// A push into a full FIFO is accepted when a pop happens on the same edge.
module responder_fifo
  import handshake_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  localparam int AW = $clog2(FIFO_DEPTH),
  localparam int CW = AW + 1
) (
  input  logic                  dest_clk,
  input  logic                  dest_reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [CW-1:0]         count,
  output logic                  full,
  output logic                  empty
);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wr_q, wr_d;
  logic [AW-1:0]         rd_q, rd_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  do_push;
  logic                  do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(FIFO_DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = wr_q + AW'(1);
    if (do_pop)  rd_d = rd_q + AW'(1);
    unique case (1'b1)
      (do_push && !do_pop): cnt_d = cnt_q + CW'(1);
      (do_pop && !do_push): cnt_d = cnt_q - CW'(1);
      default:              cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge dest_clk or posedge dest_reset) begin
    if (dest_reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      if (do_push) mem_q[wr_q] <= wdata;
    end
  end

  assign rdata = mem_q[rd_q];
  assign count = cnt_q;

endmodule

// File: rtl/handshake_responder.sv
// Receive end of the four-phase req/ack handshake with a buffered
// valid/ready output stream; ack is withheld while the FIFO is full.
module handshake_responder
  import handshake_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  dest_clk,
  input  logic                  dest_reset,
  input  logic                  req_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  ack_o,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [CW-1:0]         count_o
);

  resp_state_t state_q, state_d;
  logic        ack_q;
  logic        sreq;
  logic        push;
  logic        pop;
  logic        space;
  logic        full;
  logic        empty;

  flipflop_synchronizer #(
    .WIDTH         (1),
    .NUM_OF_STAGES (SYNC_STAGES)
  ) u_req_sync (
    .clk_i  (dest_clk),
    .rst_i  (dest_reset),
    .data_i (req_i),
    .data_o (sreq)
  );

  assign pop   = valid_o && ready_i;
  assign space = !full || pop;

  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    unique case (state_q)
      R_IDLE: begin
        if (sreq && space) begin
          push    = 1'b1;
          state_d = R_ACK;
        end else if (sreq) begin
          state_d = R_WAIT_SPACE;
        end
      end
      R_WAIT_SPACE: begin
        if (space) begin
          push    = 1'b1;
          state_d = R_ACK;
        end else if (!sreq) begin
          state_d = R_IDLE;
        end
      end
      R_ACK: begin
        if (!sreq) state_d = R_IDLE;
      end
      default: state_d = R_IDLE;
    endcase
  end

  // ack comes straight from a flop so the sender never sees a glitch
  always_ff @(posedge dest_clk or posedge dest_reset) begin
    if (dest_reset) begin
      state_q <= R_IDLE;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= (state_d == R_ACK);
    end
  end

  responder_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .dest_clk   (dest_clk),
    .dest_reset (dest_reset),
    .push       (push),
    .wdata      (data_i),
    .pop        (pop),
    .rdata      (data_out),
    .count      (count_o),
    .full       (full),
    .empty      (empty)
  );

  assign ack_o   = ack_q;
  assign valid_o = !empty;

endmodule

// File: tb/tb_handshake_responder.sv
// Randomized self-checking bench for handshake_responder against
// a queue-based reference of acked and popped words.
module tb_handshake_responder;

  logic        dest_clk = 1'b0;
  logic        dest_reset = 1'b1;
  logic        req_i = 1'b0;
  logic [31:0] data_i = '0;
  logic        ack_o;
  logic [31:0] data_out;
  logic        valid_o;
  logic        ready_i = 1'b0;
  logic [2:0]  count_o;

  int n_tests = 0;
  int n_fail  = 0;
  int max_cnt = 0;

  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];

  handshake_responder dut (
    .dest_clk   (dest_clk),
    .dest_reset (dest_reset),
    .req_i      (req_i),
    .data_i     (data_i),
    .ack_o      (ack_o),
    .data_out   (data_out),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .count_o    (count_o)
  );

  always #5 dest_clk = ~dest_clk;

  // inputs change 1ns after posedge, so negedge sees settled pop decisions
  always @(negedge dest_clk) begin
    if (!dest_reset) begin
      if (valid_o && ready_i) got_q.push_back(data_out);
      if (int'(count_o) > max_cnt) max_cnt = int'(count_o);
    end
  end

  task automatic tick();
    @(posedge dest_clk);
    #1;
  endtask

  task automatic send(input logic [31:0] w);
    bit ok;
    ok = 1'b0;
    data_i = w;
    req_i = 1'b1;
    for (int k = 0; k < 200; k++) begin
      tick();
      if (ack_o) begin
        ok = 1'b1;
        break;
      end
    end
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL send_ack word=%h ack=%b want 1", w, ack_o);
    end else begin
      exp_q.push_back(w);
    end
    req_i = 1'b0;
    for (int k = 0; k < 200 && ack_o; k++) tick();
    n_tests++;
    if (ack_o !== 1'b0) begin
      n_fail++;
      $display("FAIL send_ack_drop word=%h ack=%b want 0", w, ack_o);
    end
  endtask

  task automatic drain(input string name);
    ready_i = 1'b1;
    for (int k = 0; k < 100 && valid_o; k++) tick();
    ready_i = 1'b0;
    tick();
    n_tests++;
    if (valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_empty valid=%b want 0", name, valid_o);
    end
    n_tests++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL %s_len got=%0d want %0d", name, got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_tests++;
        if (got_q[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL %s_word[%0d] got=%h want %h", name, i, got_q[i], exp_q[i]);
        end
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    dest_reset = 1'b1;
    #3;
    n_tests++;
    if (ack_o !== 1'b0) begin
      n_fail++; $display("FAIL rst_ack got=%b want 0", ack_o);
    end
    n_tests++;
    if (valid_o !== 1'b0) begin
      n_fail++; $display("FAIL rst_valid got=%b want 0", valid_o);
    end
    n_tests++;
    if (count_o !== 3'd0) begin
      n_fail++; $display("FAIL rst_count got=%0d want 0", count_o);
    end
    n_tests++;
    if (data_out !== 32'h0) begin
      n_fail++; $display("FAIL rst_data got=%h want 0", data_out);
    end
    repeat (2) tick();
    dest_reset = 1'b0;
    tick();
  endtask

  task automatic test_single();
    int lat;
    ready_i = 1'b1;
    data_i = 32'hA5A5_0001;
    req_i = 1'b1;
    lat = 0;
    while (!ack_o && lat < 50) begin
      tick();
      lat++;
    end
    n_tests++;
    if (lat != 3) begin
      n_fail++; $display("FAIL single_rise_lat got=%0d want 3", lat);
    end
    n_tests++;
    if (valid_o !== 1'b1 || data_out !== 32'hA5A5_0001) begin
      n_fail++;
      $display("FAIL single_out valid=%b data=%h want 1 a5a50001", valid_o, data_out);
    end
    exp_q.push_back(32'hA5A5_0001);
    req_i = 1'b0;
    lat = 0;
    while (ack_o && lat < 50) begin
      tick();
      lat++;
    end
    n_tests++;
    if (lat != 3) begin
      n_fail++; $display("FAIL single_fall_lat got=%0d want 3", lat);
    end
    drain("single");
  endtask

  task automatic test_fill();
    ready_i = 1'b0;
    for (int i = 1; i <= 4; i++) send(32'(i));
    n_tests++;
    if (count_o !== 3'd4) begin
      n_fail++; $display("FAIL fill_count got=%0d want 4", count_o);
    end
    data_i = 32'd5;
    req_i = 1'b1;
    repeat (10) tick();
    n_tests++;
    if (ack_o !== 1'b0 || count_o !== 3'd4) begin
      n_fail++;
      $display("FAIL fill_wait ack=%b count=%0d want 0 4", ack_o, count_o);
    end
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    n_tests++;
    if (ack_o !== 1'b1 || count_o !== 3'd4) begin
      n_fail++;
      $display("FAIL fill_pushpop ack=%b count=%0d want 1 4", ack_o, count_o);
    end
    exp_q.push_back(32'd5);
    req_i = 1'b0;
    for (int k = 0; k < 50 && ack_o; k++) tick();
    drain("fill");
  endtask

  task automatic test_wrap();
    bit done;
    done = 1'b0;
    max_cnt = 0;
    fork
      begin
        for (int i = 1; i <= 10; i++) send(32'(i));
        done = 1'b1;
      end
      begin
        while (!done) begin
          tick();
          ready_i = ~ready_i;
        end
      end
    join
    n_tests++;
    if (max_cnt > 4) begin
      n_fail++; $display("FAIL wrap_maxcount got=%0d want <=4", max_cnt);
    end
    drain("wrap");
  endtask

  task automatic test_abort();
    bit saw;
    ready_i = 1'b0;
    for (int i = 0; i < 4; i++) send(32'h20 + 32'(i));
    saw = 1'b0;
    data_i = 32'h99;
    req_i = 1'b1;
    repeat (6) begin tick(); saw |= ack_o; end
    req_i = 1'b0;
    repeat (6) begin tick(); saw |= ack_o; end
    n_tests++;
    if (saw !== 1'b0 || count_o !== 3'd4) begin
      n_fail++;
      $display("FAIL abort_hold saw_ack=%b count=%0d want 0 4", saw, count_o);
    end
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    repeat (3) tick();
    n_tests++;
    if (ack_o !== 1'b0 || count_o !== 3'd3) begin
      n_fail++;
      $display("FAIL abort_nopush ack=%b count=%0d want 0 3", ack_o, count_o);
    end
    drain("abort");
  endtask

  task automatic test_reset_mid();
    ready_i = 1'b0;
    send(32'h31);
    data_i = 32'h32;
    req_i = 1'b1;
    for (int k = 0; k < 50 && !ack_o; k++) tick();
    n_tests++;
    if (ack_o !== 1'b1 || count_o !== 3'd2) begin
      n_fail++;
      $display("FAIL rmid_pre ack=%b count=%0d want 1 2", ack_o, count_o);
    end
    #2;
    dest_reset = 1'b1;
    #1;
    n_tests++;
    if (ack_o !== 1'b0 || valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_async ack=%b valid=%b want 0 0", ack_o, valid_o);
    end
    n_tests++;
    if (count_o !== 3'd0 || data_out !== 32'h0) begin
      n_fail++;
      $display("FAIL rmid_fifo count=%0d data=%h want 0 0", count_o, data_out);
    end
    req_i = 1'b0;
    repeat (2) tick();
    dest_reset = 1'b0;
    repeat (5) tick();
    n_tests++;
    if (valid_o !== 1'b0 || ack_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_post valid=%b ack=%b want 0 0", valid_o, ack_o);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_long_req();
    ready_i = 1'b0;
    data_i = 32'hDEAD_0020;
    req_i = 1'b1;
    repeat (20) tick();
    n_tests++;
    if (count_o !== 3'd1 || ack_o !== 1'b1) begin
      n_fail++;
      $display("FAIL long_hold count=%0d ack=%b want 1 1", count_o, ack_o);
    end
    exp_q.push_back(32'hDEAD_0020);
    req_i = 1'b0;
    for (int k = 0; k < 50 && ack_o; k++) tick();
    n_tests++;
    if (count_o !== 3'd1) begin
      n_fail++; $display("FAIL long_after count=%0d want 1", count_o);
    end
    drain("long");
  endtask

  task automatic test_random();
    bit done;
    done = 1'b0;
    max_cnt = 0;
    fork
      begin
        for (int i = 0; i < 30; i++) begin
          send($urandom);
          repeat ($urandom_range(0, 3)) tick();
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          tick();
          ready_i = ($urandom_range(0, 3) == 0);
        end
      end
    join
    n_tests++;
    if (max_cnt > 4) begin
      n_fail++; $display("FAIL rand_maxcount got=%0d want <=4", max_cnt);
    end
    drain("rand");
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_wrap();
    test_abort();
    test_reset_mid();
    test_long_req();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/handshake_responder.md
# handshake_responder

Single-clock receive end of the four-phase req/ack handshake driven by `sender_fsm`. It synchronizes the raw `req_i` into its own domain and captures the held `data_i` word into a small FIFO. It returns `ack_o` and presents captured words on a valid/ready stream to downstream logic. It replaces the bare `receiver_fsm` plus output register when the consumer needs buffering and backpressure instead of a one-deep register.

## Interface
- `DATA_WIDTH`, default 32: width of the transferred word.
- `FIFO_DEPTH`, default 4: number of buffered words; power of two, ≥2.
- `SYNC_STAGES`, default 2: flop stages on `req_i`; ≥2.
- `dest_clk`, in, 1: the only clock. One clock; reset is asynchronous and active-high.
- `dest_reset`, in, 1: asynchronous, active-high reset.
- `req_i`, in, 1: raw request from the sender domain, asynchronous to `dest_clk`.
- `data_i`, in, `DATA_WIDTH`: sender data. Stable from before `req_i` rises until `ack_o` is seen high.
- `ack_o`, out, 1: registered acknowledge back to the sender domain.
- `data_out`, out, `DATA_WIDTH`: FIFO head word.
- `valid_o`, out, 1: FIFO non-empty.
- `ready_i`, in, 1: downstream accepts the head word when `valid_o && ready_i`.
- `count_o`, out, `$clog2(FIFO_DEPTH)+1`: words currently stored.

## Operation
- `req_i` passes through `SYNC_STAGES` flops (reset 0) to give `sreq`.
- **Push and pop conditions**
  - pop = `valid_o && ready_i`.
  - space = (`count_o < FIFO_DEPTH`) || pop. A push into a full FIFO is legal in the same cycle as a pop.
- **FSM states**
  - **R_IDLE** (`ack_o`=0)
    - `sreq && space`: push `data_i`, go to R_ACK.
    - `sreq && !space`: go to R_WAIT_SPACE.
    - Otherwise stay.
  - **R_WAIT_SPACE** (`ack_o`=0)
    - `space`: push `data_i`, go to R_ACK.
    - `!sreq` (protocol abort): go to R_IDLE with no push.
  - **R_ACK** (`ack_o`=1)
    - `!sreq`: go to R_IDLE.
    - Exactly one push per handshake, regardless of how long req stays high.
- `ack_o` is the registered decode (state == R_ACK). It never glitches.
- **FIFO**
  - Circular memory with read and write pointers of width `$clog2(FIFO_DEPTH)`; both wrap modulo `FIFO_DEPTH`.
  - `count_o` +1 on push only, −1 on pop only, unchanged on push+pop.
  - `data_out` = mem[rd_ptr]; `valid_o` = (`count_o` != 0).
- Pop on an empty FIFO cannot occur, because `valid_o` gates it.

## Timing
- **Reset values:** state R_IDLE, `ack_o`=0, `valid_o`=0, `count_o`=0, `data_out`=0, pointers 0, sync flops 0, memory cleared to 0.
- **`req_i` rise → `ack_o` rise:** `SYNC_STAGES`+1 cycles when space is available (3 at default). The push happens on the same edge that raises `ack_o`.
- **`req_i` fall → `ack_o` fall:** `SYNC_STAGES`+1 cycles.
- **Pushed word:** visible on `data_out`/`valid_o` the cycle after the push edge, when the FIFO was empty.
- **Pop:** takes effect at the edge where `valid_o && ready_i`. The next word (or `valid_o`=0) appears the following cycle.
- **Full FIFO with `sreq` high:** `ack_o` is held low indefinitely. This backpressures the sender, whose ready stays low.
- **Reset mid-operation:** `ack_o` drops immediately and the FIFO contents are discarded. `dest_reset` and `src_reset` are asserted together system-wide.

## Structure
- `handshake_pkg` holds:
  - `typedef enum logic [1:0] {R_IDLE, R_WAIT_SPACE, R_ACK} resp_state_t`
  - default width, depth and stage constants
- Reuse `flipflop_synchronizer` (`WIDTH`=1, `NUM_OF_STAGES`=`SYNC_STAGES`) for req.
- One new sub-module, `responder_fifo`:
  - ports: `dest_clk`, `dest_reset`, push, `wdata`, pop, `rdata`, `count`, full, empty
  - the FSM and glue stay in the top.

## Test plan
- **Single transfer:** `data_i`=32'hA5A5_0001, raise `req_i`, `ready_i`=1.
  - `ack_o` rises 3 cycles later.
  - Next cycle: `valid_o`=1 and `data_out`=32'hA5A5_0001.
  - Drop `req_i`: `ack_o` falls 3 cycles later.
- **Fill:** `ready_i`=0, send 4 words 1..4.
  - After the 4th, `count_o`=4.
  - The 5th request (word 5) keeps `ack_o`=0 in R_WAIT_SPACE.
  - One pop: word 5 is pushed, `ack_o` rises, `count_o` stays 4.
  - Drain order is 1..5.
- **Wrap-around:** 10 transfers with `ready_i` toggling every cycle. Output order matches 1..10 and `count_o` never exceeds 4.
- **Abort:** FIFO full, raise then drop `req_i` before space frees. Result: no push, `ack_o` stays 0, state returns to R_IDLE.
- **Reset mid-handshake:** assert `dest_reset` while `ack_o`=1 and `count_o`=2. Outputs go to reset values asynchronously and `valid_o`=0.
- **Long req:** hold `req_i` high for 20 cycles. Exactly one push occurs and `count_o` increments by 1.
